// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bundle between the MEM stage and data memory.
// master: MEM stage (drives req/we/addr/wdata); slave: memory (drives ack/rdata).
interface mem_stage_ctrl_if #(
    parameter int DW = 32
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: decodes MEM/WB control, runs a req/ack access to a
// variable-latency data memory, stalls upstream while busy, drives MEM/WB.
// Ports: clk, rst_n (async low); EX/MEM inputs MEMin, WBin, ALUresin, r2in,
// regresin; stall; dmem (master modport); MEM/WB outputs WB, memdata, ALUres,
// regres; bus_err.
// Optional: define MEM_TIMEOUT_EN to enable the BUSY timeout and bus_err.
module mem_stage_ctrl #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       MEMin,
    input  logic [1:0]       WBin,
    input  logic [DW-1:0]    ALUresin,
    input  logic [DW-1:0]    r2in,
    input  logic [RW-1:0]    regresin,
    output logic             stall,
    mem_stage_ctrl_if.master dmem,
    output logic [1:0]       WB,
    output logic [DW-1:0]    memdata,
    output logic [DW-1:0]    ALUres,
    output logic [RW-1:0]    regres,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    wb_q, wb_d;
    logic [DW-1:0] memdata_q, memdata_d;
    logic [DW-1:0] alures_q, alures_d;
    logic [RW-1:0] regres_q, regres_d;
    // Instruction fields captured at issue, replayed into MEM/WB in DONE.
    logic [1:0]    lwb_q, lwb_d;
    logic [DW-1:0] lalu_q, lalu_d;
    logic [RW-1:0] lreg_q, lreg_d;
    // Load data waits here until the single MEM/WB write in DONE.
    logic [DW-1:0] stage_q, stage_d;
    logic          stall_c;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expire;

    // Current BUSY cycle is the TIMEOUT-th one without ack.
    assign expire = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_d      = wb_q;
        memdata_d = memdata_q;
        alures_d  = alures_q;
        regres_d  = regres_q;
        lwb_d     = lwb_q;
        lalu_d    = lalu_q;
        lreg_d    = lreg_q;
        stage_d   = stage_q;
        stall_c   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                stall_c = |MEMin;
                if (|MEMin) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    // MemRead has priority when both bits are set.
                    we_d    = ~MEMin[1];
                    addr_d  = ALUresin;
                    wdata_d = r2in;
                    lwb_d   = WBin;
                    lalu_d  = ALUresin;
                    lreg_d  = regresin;
                    wb_d    = 2'b00;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    wb_d     = WBin;
                    alures_d = ALUresin;
                    regres_d = regresin;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        stage_d = dmem.dmem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (expire) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        stage_d = DW'(32'hDEAD_BEEF);
                    end
                end else if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            DONE: begin
                // Same instruction still on EX/MEM: retire it, never re-issue.
                state_d  = IDLE;
                wb_d     = lwb_q;
                alures_d = lalu_q;
                regres_d = lreg_q;
                if (!we_q) begin
                    memdata_d = stage_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= 2'b00;
            memdata_q <= '0;
            alures_q  <= '0;
            regres_q  <= '0;
            lwb_q     <= 2'b00;
            lalu_q    <= '0;
            lreg_q    <= '0;
            stage_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            memdata_q <= memdata_d;
            alures_q  <= alures_d;
            regres_q  <= regres_d;
            lwb_q     <= lwb_d;
            lalu_q    <= lalu_d;
            lreg_q    <= lreg_d;
            stage_q   <= stage_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

    // Gated so every output reads 0 while reset is asserted.
    assign stall           = rst_n & stall_c;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign WB              = wb_q;
    assign memdata         = memdata_q;
    assign ALUres          = alures_q;
    assign regres          = regres_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed cases plus random instruction stream
// checked against a transaction-level model of the MEM/WB register.
module tb_mem_stage_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    MEMin;
    logic [1:0]    WBin;
    logic [DW-1:0] ALUresin;
    logic [DW-1:0] r2in;
    logic [RW-1:0] regresin;
    logic          stall;
    logic [1:0]    WB;
    logic [DW-1:0] memdata;
    logic [DW-1:0] ALUres;
    logic [RW-1:0] regres;
    logic          bus_err;

    int checks = 0;
    int errors = 0;

    // Model: last value loaded into MEM/WB memdata, and sticky error.
    logic [DW-1:0] m_memdata;
    logic          m_err;

    mem_stage_ctrl_if #(.DW(DW)) dmem_bus ();

    mem_stage_ctrl #(
        .DW(DW),
        .RW(RW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MEMin(MEMin),
        .WBin(WBin),
        .ALUresin(ALUresin),
        .r2in(r2in),
        .regresin(regresin),
        .stall(stall),
        .dmem(dmem_bus),
        .WB(WB),
        .memdata(memdata),
        .ALUres(ALUres),
        .regres(regres),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mewb(input logic [1:0] wb, input logic [DW-1:0] alu,
                            input logic [RW-1:0] rg);
        chk("mewb_wb", WB, wb);
        chk("mewb_alu", ALUres, alu);
        chk("mewb_reg", regres, rg);
        chk("mewb_mem", memdata, m_memdata);
        chk("bus_err", bus_err, m_err);
    endtask

    task automatic alu_op(input logic [1:0] wb, input logic [DW-1:0] alu,
                          input logic [RW-1:0] rg);
        MEMin    = 2'b00;
        WBin     = wb;
        ALUresin = alu;
        r2in     = $urandom;
        regresin = rg;
        #1;
        chk("alu_stall", stall, 0);
        tick();
        chk("alu_noreq", dmem_bus.dmem_req, 0);
        chk_mewb(wb, alu, rg);
    endtask

    // Memory access with ack in BUSY cycle number lat (1-based).
    task automatic mem_op(input logic [1:0] mem, input logic [1:0] wb,
                          input logic [DW-1:0] alu, input logic [DW-1:0] r2,
                          input logic [RW-1:0] rg, input int lat,
                          input logic [DW-1:0] rd);
        int nst;
        nst      = 0;
        MEMin    = mem;
        WBin     = wb;
        ALUresin = alu;
        r2in     = r2;
        regresin = rg;
        #1;
        chk("issue_stall", stall, 1);
        chk("issue_noreq", dmem_bus.dmem_req, 0);
        if (stall) nst++;
        tick();
        chk("bubble_wb", WB, 0);
        for (int k = 0; k < lat; k++) begin
            chk("busy_req", dmem_bus.dmem_req, 1);
            chk("busy_we", dmem_bus.dmem_we, !mem[1]);
            chk("busy_addr", dmem_bus.dmem_addr, alu);
            chk("busy_wdata", dmem_bus.dmem_wdata, r2);
            if (stall) nst++;
            dmem_bus.dmem_ack   = (k == lat - 1);
            dmem_bus.dmem_rdata = (k == lat - 1) ? rd : DW'($urandom);
            tick();
            dmem_bus.dmem_ack = 1'b0;
        end
        chk("done_req", dmem_bus.dmem_req, 0);
        chk("done_stall", stall, 0);
        chk("done_bubble", WB, 0);
        chk("stall_cycles", nst, lat + 1);
        if (mem[1]) m_memdata = rd;
        tick();
        chk("noreissue", dmem_bus.dmem_req, 0);
        chk_mewb(wb, alu, rg);
    endtask

    initial begin
        logic [1:0] rm;
        int         rl;
        MEMin               = 2'b00;
        WBin                = 2'b00;
        ALUresin            = '0;
        r2in                = '0;
        regresin            = '0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        m_memdata           = '0;
        m_err               = 1'b0;

        tick();
        tick();
        chk("rst_req", dmem_bus.dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk_mewb(2'b00, '0, '0);
        rst_n = 1'b1;

        alu_op(2'b01, 32'd5, 5'd3);
        mem_op(2'b10, 2'b11, 32'h40, 32'h0, 5'd7, 1, 32'h1234);
        mem_op(2'b01, 2'b00, 32'h80, 32'hCAFE, 5'd0, 4, 32'h5555_AAAA);
        mem_op(2'b11, 2'b11, 32'h44, 32'h99, 5'd9, 2, 32'hBEEF_0001);

        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h7777_7777;
        alu_op(2'b10, 32'hABCD, 5'd12);
        dmem_bus.dmem_ack   = 1'b0;
        alu_op(2'b01, 32'h11, 5'd1);

        MEMin    = 2'b10;
        ALUresin = 32'h100;
        tick();
        chk("pre_rst_req", dmem_bus.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        m_memdata = '0;
        chk("rst_mid_req", dmem_bus.dmem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_we", dmem_bus.dmem_we, 0);
        chk("rst_mid_addr", dmem_bus.dmem_addr, 0);
        chk("rst_mid_wdata", dmem_bus.dmem_wdata, 0);
        chk_mewb(2'b00, '0, '0);
        tick();
        MEMin = 2'b00;
        tick();
        rst_n = 1'b1;
        alu_op(2'b01, 32'h22, 5'd4);
        mem_op(2'b10, 2'b11, 32'h8, 32'h0, 5'd6, 3, 32'h0BAD_F00D);

`ifdef MEM_TIMEOUT_EN
        mem_op(2'b10, 2'b11, 32'h60, 32'h0, 5'd2, TO, 32'h600D_600D);
        MEMin    = 2'b10;
        WBin     = 2'b11;
        ALUresin = 32'h70;
        regresin = 5'd8;
        tick();
        for (int k = 0; k < TO; k++) begin
            chk("to_req", dmem_bus.dmem_req, 1);
            chk("to_err0", bus_err, 0);
            tick();
        end
        m_err     = 1'b1;
        m_memdata = 32'hDEAD_BEEF;
        chk("to_req_drop", dmem_bus.dmem_req, 0);
        chk("to_err", bus_err, 1);
        tick();
        chk_mewb(2'b11, 32'h70, 5'd8);
        alu_op(2'b01, 32'h33, 5'd5);
`else
        mem_op(2'b01, 2'b00, 32'h90, 32'h1, 5'd2, 40, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom_range(0, 3));
            rl = $urandom_range(1, 5);
            if (rm == 2'b00)
                alu_op(2'($urandom), $urandom, 5'($urandom));
            else
                mem_op(rm, 2'($urandom), $urandom, $urandom,
                       5'($urandom), rl, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
